// File: rtl/spram_loader_pkg.sv
// rtl/spram_loader_pkg.sv - shared constants and FSM encoding for the SPRAM flash FIFO unpacker
package spram_loader_pkg;

  localparam int FIFO_WORD_W = 32;
  localparam int MAX_WORDS   = 16384;
  localparam int BYTE_W      = 8;
  localparam int STATE_W     = 3;

  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] ST_FILL  = 3'd1;
  localparam logic [STATE_W-1:0] ST_WAIT  = 3'd2;
  localparam logic [STATE_W-1:0] ST_FETCH = 3'd3;
  localparam logic [STATE_W-1:0] ST_SHIFT = 3'd4;
  localparam logic [STATE_W-1:0] ST_DONE  = 3'd5;

  // The FIFO read pointer stays live only while a word session is in flight.
  function automatic logic fill_active(input logic [STATE_W-1:0] state);
    return (state == ST_FILL) || (state == ST_WAIT) ||
           (state == ST_FETCH) || (state == ST_SHIFT);
  endfunction

endpackage

// File: rtl/spram_byte_serializer.sv
// rtl/spram_byte_serializer.sv - 32-bit word load, LSB-first 8-bit valid/ready shift-out
module spram_byte_serializer
  import spram_loader_pkg::*;
(
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   i_load,
  input  logic [FIFO_WORD_W-1:0] i_word,
  output logic [BYTE_W-1:0]      o_tdata,
  output logic                   o_tvalid,
  input  logic                   i_tready,
  output logic                   o_tlast
);

  logic [FIFO_WORD_W-1:0] r_shift;
  logic [1:0]             r_idx;
  logic                   r_valid;
  logic                   w_xfer;

  assign w_xfer = r_valid && i_tready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_shift <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_shift <= i_word;
      r_idx   <= '0;
      r_valid <= 1'b1;
    end else if (w_xfer) begin
      // The last byte stays in the register; only valid drops.
      if (r_idx == 2'd3) begin
        r_valid <= 1'b0;
      end else begin
        r_shift <= {{BYTE_W{1'b0}}, r_shift[FIFO_WORD_W-1:BYTE_W]};
        r_idx   <= r_idx + 2'd1;
      end
    end
  end

  assign o_tdata  = r_shift[BYTE_W-1:0];
  assign o_tvalid = r_valid;
  assign o_tlast  = (r_idx == 2'd3);

endmodule

// File: rtl/spram_word_unpacker.sv
// rtl/spram_word_unpacker.sv - pops N words from the SPRAM flash FIFO and streams them as bytes; option SPRAM_UNPACK_CHKSUM_EN adds o_chksum
module spram_word_unpacker #(
  parameter int CNT_W     = 16,
  parameter int MAX_WORDS = spram_loader_pkg::MAX_WORDS
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_word_count,
  output logic             o_fill,
  input  logic             i_fifo_empty,
  output logic             o_fifo_rd,
  input  logic [31:0]      i_fifo_dout,
  output logic [7:0]       o_byte,
  output logic             o_byte_valid,
  input  logic             i_byte_ready,
  output logic             o_busy,
  output logic             o_done
`ifdef SPRAM_UNPACK_CHKSUM_EN
  ,
  output logic [15:0]      o_chksum
`endif
);

  import spram_loader_pkg::*;

  localparam int               CW     = CNT_W + 1;
  localparam logic [CNT_W:0]   LP_MAX = CW'(MAX_WORDS);
  localparam logic [CNT_W:0]   LP_ONE = CW'(1);

  logic [STATE_W-1:0] r_state;
  // One bit wider than the request so a clamp-limited count never wraps.
  logic [CNT_W:0]     r_count;
  logic [CNT_W:0]     r_words;

  logic [CNT_W:0]     w_req;
  logic [CNT_W:0]     w_clamped;
  logic               w_start_ok;
  logic               w_load;
  logic               w_valid;
  logic               w_last;
  logic               w_xfer;
  logic [7:0]         w_byte;

  assign w_req      = {1'b0, i_word_count};
  assign w_clamped  = (w_req > LP_MAX) ? LP_MAX : w_req;
  assign w_start_ok = i_start && (r_state == ST_IDLE);
  assign w_load     = (r_state == ST_FETCH);
  assign w_xfer     = w_valid && i_byte_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_words <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start_ok) begin
            r_count <= w_clamped;
            r_words <= '0;
            r_state <= (w_clamped == '0) ? ST_DONE : ST_FILL;
          end
        end
        ST_FILL: r_state <= ST_WAIT;
        ST_WAIT: begin
          // An empty FIFO here means the flash preload is still running.
          if (!i_fifo_empty) begin
            r_state <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          r_words <= r_words + LP_ONE;
          r_state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (w_xfer && w_last) begin
            r_state <= (r_words == r_count) ? ST_DONE : ST_WAIT;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  spram_byte_serializer u_ser (
    .clk      (clk),
    .resetn   (resetn),
    .i_load   (w_load),
    .i_word   (i_fifo_dout),
    .o_tdata  (w_byte),
    .o_tvalid (w_valid),
    .i_tready (i_byte_ready),
    .o_tlast  (w_last)
  );

  assign o_fill       = fill_active(r_state);
  assign o_fifo_rd    = (r_state == ST_FETCH) && !i_fifo_empty;
  assign o_byte       = w_byte;
  assign o_byte_valid = w_valid;
  assign o_busy       = (r_state != ST_IDLE);
  assign o_done       = (r_state == ST_DONE);

`ifdef SPRAM_UNPACK_CHKSUM_EN
  logic [15:0] r_chksum;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_chksum <= '0;
    end else if (w_start_ok) begin
      r_chksum <= '0;
    end else if (w_xfer) begin
      r_chksum <= r_chksum + {8'h00, w_byte};
    end
  end

  assign o_chksum = r_chksum;
`endif

endmodule

// File: tb/tb_spram_word_unpacker.sv
// tb/tb_spram_word_unpacker.sv - randomized bench for spram_word_unpacker with a FIFO model and byte scoreboard
module tb_spram_word_unpacker;

  localparam int TB_MAX    = 1024;
  localparam int TB_BUDGET = 20000;

  logic        clk;
  logic        resetn;
  logic        i_start;
  logic [15:0] i_word_count;
  logic        o_fill;
  logic        fifo_empty;
  logic        o_fifo_rd;
  logic [31:0] fifo_dout;
  logic [7:0]  o_byte;
  logic        o_byte_valid;
  logic        i_byte_ready;
  logic        o_busy;
  logic        o_done;
`ifdef SPRAM_UNPACK_CHKSUM_EN
  logic [15:0] o_chksum;
`endif

  spram_word_unpacker #(.CNT_W(16), .MAX_WORDS(TB_MAX)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .i_start      (i_start),
    .i_word_count (i_word_count),
    .o_fill       (o_fill),
    .i_fifo_empty (fifo_empty),
    .o_fifo_rd    (o_fifo_rd),
    .i_fifo_dout  (fifo_dout),
    .o_byte       (o_byte),
    .o_byte_valid (o_byte_valid),
    .i_byte_ready (i_byte_ready),
    .o_busy       (o_busy),
    .o_done       (o_done)
`ifdef SPRAM_UNPACK_CHKSUM_EN
    ,
    .o_chksum     (o_chksum)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // FIFO model: dout follows the read pointer, which advances one cycle after a pop.
  logic [31:0] mem [TB_MAX];
  int          rd_ptr = 0;
  logic        force_empty;

  always @(posedge clk) begin
    if (!o_fill) rd_ptr <= 0;
    else if (o_fifo_rd && !fifo_empty) rd_ptr <= rd_ptr + 1;
  end
  assign fifo_empty = force_empty || (rd_ptr >= TB_MAX);
  assign fifo_dout  = (rd_ptr < TB_MAX) ? mem[rd_ptr] : 32'h0;

  int ready_mode = 0;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       i_byte_ready = 1'b1;
      1:       i_byte_ready = ((cyc % 3) == 0);
      default: i_byte_ready = 1'($urandom_range(0, 1));
    endcase
  end

  logic [7:0] exp_q[$];
  int   pops, nbytes, dones, unstable, rd_empty, fill_cnt, valid_cnt, first_valid;
  bit   hold_pending;
  logic [7:0] held_byte;
  logic [7:0] exp_b;

  always @(negedge clk) begin
    if (resetn) begin
      if (o_fifo_rd) begin
        pops++;
        if (fifo_empty) rd_empty++;
      end
      if (o_done) dones++;
      if (o_fill) fill_cnt++;
      if (o_byte_valid) begin
        valid_cnt++;
        if (first_valid < 0) first_valid = cyc;
        if (hold_pending && (o_byte != held_byte)) unstable++;
        if (i_byte_ready) begin
          nbytes++;
          hold_pending = 1'b0;
          if (exp_q.size() == 0) begin
            check_eq("extra_byte", {24'h0, o_byte}, 32'hFFFF_FFFF);
          end else begin
            exp_b = exp_q.pop_front();
            check_eq("byte", {24'h0, o_byte}, {24'h0, exp_b});
          end
        end else begin
          hold_pending = 1'b1;
          held_byte    = o_byte;
        end
      end else if (hold_pending) begin
        unstable++;
        hold_pending = 1'b0;
      end
    end
  end

  task automatic clear_stats();
    pops = 0; nbytes = 0; dones = 0; unstable = 0; rd_empty = 0;
    fill_cnt = 0; valid_cnt = 0; first_valid = -1; hold_pending = 1'b0;
  endtask

  task automatic load_expect(input int nw, output int sum);
    logic [31:0] w;
    exp_q.delete();
    sum = 0;
    for (int i = 0; i < nw; i++) begin
      w = mem[i];
      for (int b = 0; b < 4; b++) begin
        exp_q.push_back(w[8*b +: 8]);
        sum += int'(w[8*b +: 8]);
      end
    end
  endtask

  task automatic run_session(input int n, input int mode, input int extra_at, input int stall);
    int nw, exp_sum, start_cyc, drop_cyc, done_cyc;
    bit seen;
    nw = (n > TB_MAX) ? TB_MAX : n;
    load_expect(nw, exp_sum);
    clear_stats();
    ready_mode = mode;
    if (stall > 0) force_empty = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b1; i_word_count = 16'(n); start_cyc = cyc;
    @(posedge clk); #1;
    i_start = 1'b0;
    seen = 1'b0; drop_cyc = -1; done_cyc = -1;
    for (int k = 0; k < TB_BUDGET && !seen; k++) begin
      @(negedge clk);
      if (o_done) begin
        seen = 1'b1; done_cyc = cyc;
      end else if (stall > 0 && drop_cyc < 0 && (cyc - start_cyc) >= stall) begin
        check_eq("stall_fill", {31'h0, o_fill}, 32'd1);
        check_eq("stall_pops", pops, 0);
        check_eq("stall_valid", valid_cnt, 0);
        @(posedge clk); #1;
        force_empty = 1'b0; drop_cyc = cyc;
      end else if (extra_at > 0 && (cyc - start_cyc) == extra_at) begin
        @(posedge clk); #1;
        i_start = 1'b1; i_word_count = 16'd5;
        @(posedge clk); #1;
        i_start = 1'b0;
      end
    end
    check_eq("done_seen", {31'h0, seen}, 32'd1);
    @(negedge clk);
    check_eq("busy_after_done", {31'h0, o_busy}, 32'd0);
    check_eq("done_cnt", dones, 1);
    check_eq("pops", pops, nw);
    check_eq("bytes", nbytes, 4 * nw);
    check_eq("leftover", exp_q.size(), 0);
    check_eq("unstable", unstable, 0);
    check_eq("rd_while_empty", rd_empty, 0);
    if (nw == 0) begin
      check_eq("zero_fill", fill_cnt, 0);
      check_eq("zero_valid", valid_cnt, 0);
      check_eq("zero_done_lat", {31'h0, (done_cyc > start_cyc) && (done_cyc - start_cyc <= 2)}, 32'd1);
    end else if (stall > 0) begin
      check_eq("stall_lat", first_valid - drop_cyc, 2);
    end else begin
      check_eq("start_lat", first_valid - start_cyc, 4);
    end
`ifdef SPRAM_UNPACK_CHKSUM_EN
    check_eq("chksum", {16'h0, o_chksum}, exp_sum & 32'hFFFF);
`endif
    force_empty = 1'b0;
  endtask

  int dummy_sum;

  initial begin
    resetn = 1'b0; i_start = 1'b0; i_word_count = '0;
    force_empty = 1'b0; i_byte_ready = 1'b1;
    clear_stats();
    mem[0] = 32'h0403_0201;
    mem[1] = 32'h0807_0605;
    for (int i = 2; i < TB_MAX; i++) mem[i] = $urandom;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_outs", {18'h0, o_fill, o_fifo_rd, o_byte_valid, o_busy, o_done, o_byte}, 32'd0);
    resetn = 1'b1;

    run_session(2, 0, 0, 0);
    run_session(0, 0, 0, 0);
    run_session(1, 1, 0, 0);
    run_session(2, 0, 0, 50);
    run_session(20000, 2, 30, 0);
    for (int s = 0; s < 5; s++) begin
      run_session(int'($urandom_range(1, 6)), int'($urandom_range(0, 2)), 0, 0);
    end

    // Abort a session after its second byte, then confirm a fresh start replays word 0.
    load_expect(3, dummy_sum);
    clear_stats();
    ready_mode = 0;
    @(posedge clk); #1;
    i_start = 1'b1; i_word_count = 16'd3;
    @(posedge clk); #1;
    i_start = 1'b0;
    for (int k = 0; k < 50 && nbytes < 2; k++) @(negedge clk);
    check_eq("abort_bytes", nbytes, 2);
    @(posedge clk); #3;
    resetn = 1'b0;
    #1;
    check_eq("abort_outs", {18'h0, o_fill, o_fifo_rd, o_byte_valid, o_busy, o_done, o_byte}, 32'd0);
`ifdef SPRAM_UNPACK_CHKSUM_EN
    check_eq("abort_chksum", {16'h0, o_chksum}, 32'd0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    exp_q.delete();
    run_session(1, 0, 0, 0);
`ifdef SPRAM_UNPACK_CHKSUM_EN
    check_eq("replay_chksum", {16'h0, o_chksum}, 32'h0000_000A);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spram_word_unpacker.md
Name: spram_word_unpacker

Overview:
- Downstream consumer of the SPRAM-backed flash FIFO (32-bit little-endian words preloaded from SPI flash).
- Drives the FIFO fill/read handshake and pops a programmed number of words.
- Serialises each word into bytes, LSB first, on a valid/ready stream toward the CNN weight/image loader or RISC-V byte port.
- Reports busy/done, so firmware can stream a region once the flash load has completed.

Parameters:
- CNT_W, 16, width of the word-count input and internal word counter.
- MAX_WORDS, 16384, SPRAM FIFO depth in words; requested counts above this are clamped to it.

Ports:
- clk  in  1  system clock (same as RISC-V clock).
- resetn  in  1  asynchronous active-low reset.
- i_start  in  1  one-cycle start pulse; ignored unless idle.
- i_word_count  in  CNT_W  number of 32-bit words to stream; sampled on i_start.
- o_fill  out  1  FIFO fill enable; held high for the whole session, low otherwise (low rewinds the FIFO read pointer).
- i_fifo_empty  in  1  FIFO empty; when low, i_fifo_dout holds the current head word.
- o_fifo_rd  out  1  one-cycle pop strobe; next word appears on i_fifo_dout one cycle later.
- i_fifo_dout  in  32  FIFO head word.
- o_byte  out  8  output byte.
- o_byte_valid  out  1  byte valid.
- i_byte_ready  in  1  sink ready; a byte transfers when valid & ready.
- o_busy  out  1  session active (any state other than IDLE).
- o_done  out  1  one-cycle pulse when the last byte has transferred, or on a zero-count start.

Behaviour:
- All outputs reset to 0, including o_byte, the shift register and all counters. Reset mid-session aborts immediately; o_fill drops, which rewinds the FIFO.
- FSM states, with transitions:
  - IDLE: on i_start, latch the count as min(i_word_count, MAX_WORDS) and clear the word counter. Go to DONE if the latched count is 0, else go to FILL.
  - FILL: assert o_fill; go to WAIT.
  - WAIT: o_fill stays high. When i_fifo_empty=0, go to FETCH.
  - FETCH: only entered with i_fifo_empty=0. Capture i_fifo_dout into the shift register, pulse o_fifo_rd for exactly this cycle, increment the word counter, clear the byte index, and go to SHIFT.
  - SHIFT: o_byte = shift[7:0]; o_byte_valid=1.
    - On valid & ready with byte index < 3: shift right by 8 and increment the index.
    - On valid & ready with index 3 and words sent == count: go to DONE.
    - On valid & ready with index 3 and words sent < count: go to WAIT. The pop from the previous FETCH is visible there after one cycle.
    - o_byte must stay stable while valid & !ready.
  - DONE: o_done=1 for one cycle, o_fill=0, o_byte_valid=0; go to IDLE.
- Latency:
  - i_start to first o_byte_valid is 4 cycles minimum (FILL, WAIT, FETCH, then SHIFT) when the FIFO is already non-empty.
  - Per word, throughput is 4 byte beats plus a 2-cycle WAIT/FETCH gap at full ready.
- o_fifo_rd is never asserted while i_fifo_empty=1. At most one pop is issued per FETCH.
- i_fifo_empty rising during WAIT (flash load not finished) simply stalls the FSM; there is no timeout.
- i_start while busy is ignored; the latched count is not changed.
- The word counter is CNT_W+1 bits wide, so a clamped count of 16384 does not wrap.
- Byte order: byte0 = word[7:0] first, through byte3 = word[31:24].

Optional Feature:
- Macro: SPRAM_UNPACK_CHKSUM_EN.
- When defined, add output o_chksum (16 bits):
  - It is cleared on accepted i_start.
  - The zero-extended value of every transferred byte is added to it, mod 2^16.
  - It holds its value after o_done until the next start.
  - It resets to 0.
- When undefined, the port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package (spram_loader_pkg) holds:
  - the FSM state encoding localparams (IDLE, FILL, WAIT, FETCH, SHIFT, DONE);
  - MAX_WORDS = 16384 and the FIFO word width of 32.
- One sub-module is natural: spram_byte_serializer (32-bit load, 8-bit valid/ready shift-out with a last-byte flag). The FSM and counters live in the top.

Test Plan:
- FIFO holds 0x04030201 and 0x08070605; start with count=2 and ready tied 1 -> bytes 01..08 in order, exactly 2 o_fifo_rd pulses, o_done once, o_busy falls the cycle after o_done.
- Count=0 -> o_done pulses 2 cycles after i_start; o_fill, o_fifo_rd and o_byte_valid never assert.
- Count=1, ready toggling 1,0,0,1,... -> each byte is held stable while ready=0, 4 transfers total, one pop.
- i_fifo_empty=1 for 50 cycles after start, then 0 -> FSM stays in WAIT with o_fill=1 and no pop; streaming starts 2 cycles after empty falls.
- Count=20000 -> exactly 16384 pops and 65536 byte transfers before o_done; a second i_start mid-session is ignored.
- Assert resetn low mid-word (after byte 2) -> all outputs 0 asynchronously; a new start with count=1 replays from FIFO word 0. With SPRAM_UNPACK_CHKSUM_EN, bytes 01 02 03 04 give o_chksum = 0x000A.
